fuel_sequencer: RTL
===================

# fuel_sequencer

Controller that sequences the fuel-calculation datapath over the parsed-number RAM. After `start`, it walks RAM entries `0..count-1`, issuing one read per entry. For each mass it runs the repeated `floor(m/3) - 2` iteration on an internal multi-cycle restoring divider, and keeps two results: the first-iteration fuel sum (part 1) and the fully iterated fuel sum (part 2). It replaces the free-running loop/halt glue that sits between the number RAM and the accumulator register.

## Interface

**Parameters**
- `DATA_WIDTH`, default 64: RAM word and mass width.
- `ADDR_WIDTH`, default 11: RAM address width (covers 1250 words).
- `SUM_WIDTH`, default 64: accumulator width.

**Ports**
- `clk`, input, 1: the only clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begins a run. Sampled only in IDLE or DONE.
- `count`, input, ADDR_WIDTH: number of entries to process. Latched on an accepted `start`.
- `mem_rd`, output, 1: RAM read strobe.
- `mem_addr`, output, ADDR_WIDTH: RAM word address.
- `mem_data`, input, DATA_WIDTH: RAM read data, valid exactly 1 cycle after `mem_rd`.
- `busy`, output, 1: high in every state except IDLE and DONE.
- `done`, output, 1: high while in DONE.
- `part1_sum`, output, SUM_WIDTH: sum of first-iteration fuel.
- `total_sum`, output, SUM_WIDTH: sum of fully iterated fuel.
- `ovf`, output, 1: sticky flag, set on carry-out of either accumulator.

## Operation

**States:** IDLE, FETCH, LOAD, DIV, EVAL, DONE.

- **IDLE / DONE, `start`=1:**
  - Latch `count`.
  - Clear `idx`, both sums and `ovf`.
  - Go to DONE if `count`==0, else FETCH.
  - Hold `part1_sum` and `total_sum` stable until that `start` is accepted.
- **FETCH (1 cycle):** drive `mem_rd`=1 and `mem_addr`=`idx`. Go to LOAD.
- **LOAD (1 cycle):**
  - Set `m` = `mem_data`.
  - Set `first`=1.
  - Initialise the divider: quotient 0, remainder 0, bit pointer DATA_WIDTH-1.
  - Go to DIV.
- **DIV (exactly DATA_WIDTH cycles):** one restoring-division step per cycle, MSB first.
  - `rem` = {`rem`, `m[bit]`}.
  - If `rem` >= 3, subtract 3 and set the quotient bit.
  - The remainder needs only 3 bits internally.
  - After the last bit, go to EVAL with `q` = `floor(m/3)`.
- **EVAL (1 cycle):**
  - If `q` > 2:
    - `total_sum` += `q-2`.
    - If `first`, `part1_sum` += `q-2`.
    - `m` = `q-2`, `first`=0, go to DIV.
  - Else (fuel <= 0, stop):
    - `idx`++.
    - Go to DONE if `idx`+1 == latched count, else FETCH.
- **Part-1 clamp:** a mass whose first `q` <= 2 contributes 0 to `part1_sum`.
- **Arithmetic:** fuel values are zero-extended to SUM_WIDTH. Sums wrap modulo 2^SUM_WIDTH. `ovf` is set on any carry-out and held until the next accepted `start` or `rst`.
- **`start` while busy:** ignored and has no effect.
- **`rst` at any time (including mid-run):** immediately forces IDLE and clears all registers and outputs.

## Timing

**Reset values:**
- `mem_rd`=0, `mem_addr`=0, `busy`=0, `done`=0.
- `part1_sum`=0, `total_sum`=0, `ovf`=0.

**Outputs:** all registered, except `mem_rd`, `mem_addr`, `busy` and `done`, which decode from state and `idx` (no combinational input-to-output path).

**Latency:**
- A mass that yields k positive fuel steps takes `2 + (k+1)*(DATA_WIDTH+1)` cycles.
- `done` rises `1 + Σ(entry cycles)` cycles after the cycle in which `start` is accepted.
- With `count`=0, `done` rises 1 cycle after `start`.

**Read protocol:** exactly one `mem_rd` per entry, in ascending address order, never issued outside FETCH.

**Sum update timing:** sums update only on the EVAL clock edge, so intermediate values are visible while `busy`=1.

## Test plan

- **Single mass:** RAM[0]=12, `count`=1, DATA_WIDTH=64, `start` at cycle 0.
  - Required: `done` rises at cycle 133.
  - Required: `part1_sum`=2, `total_sum`=2, `ovf`=0.
- **Four masses:** RAM={12, 14, 1969, 100756}, `count`=4.
  - Required: `part1_sum`=34241, `total_sum`=51316.
  - Required: addresses read in order 0,1,2,3, one `mem_rd` each.
- **Boundary masses:** RAM={0, 8, 9}, `count`=3.
  - Required: `part1_sum`=1, `total_sum`=1 (9→1, then 1→stop; 0 and 8 contribute 0).
- **Empty run and restart:**
  - `count`=0 → `done`=1 one cycle later, both sums 0.
  - `start` during a 1969 run → ignored; sums match the uninterrupted result.
  - `start` in DONE → sums cleared and the run restarts.
- **Reset mid-run:** assert `rst` during DIV of entry 2.
  - Required: all outputs 0 the same cycle, state IDLE.
  - A subsequent run gives the correct sums.
- **Overflow:** SUM_WIDTH=16, RAM={200000}.
  - Required: `total_sum` = true total mod 65536, and `ovf`=1 until the next `start`.

Source files
------------

// File: rtl/fuel_sequencer.sv
// Walks the number RAM, iterating floor(m/3)-2 on a serial restoring divider
// per mass, and accumulates first-step fuel (part 1) and fully iterated fuel (total).
module fuel_sequencer #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 11,
   parameter int SUM_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] count,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  busy,
   output logic                  done,
   output logic [SUM_WIDTH-1:0]  part1_sum,
   output logic [SUM_WIDTH-1:0]  total_sum,
   output logic                  ovf
);

   // state   | meaning
   // S_IDLE  | after reset, waiting for start
   // S_FETCH | read strobe for entry idx
   // S_LOAD  | capture RAM word, arm divider
   // S_DIV   | one quotient bit per cycle, MSB first
   // S_EVAL  | accumulate q-2 and iterate, or move to next entry
   // S_DONE  | results held until the next start
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_DIV,
      S_EVAL,
      S_DONE
   } state_t;

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   // Adder wide enough that a fuel value wider than the sum still flags ovf.
   localparam int WW = ((SUM_WIDTH > DATA_WIDTH) ? SUM_WIDTH : DATA_WIDTH) + 1;
   localparam logic [BW-1:0] BIT_MSB = BW'(DATA_WIDTH - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [DATA_WIDTH-1:0] m_q, m_d;
   logic [DATA_WIDTH-1:0] q_q, q_d;
   logic [1:0]            rem_q, rem_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  first_q, first_d;
   logic [SUM_WIDTH-1:0]  part1_q, part1_d;
   logic [SUM_WIDTH-1:0]  total_q, total_d;
   logic                  ovf_q, ovf_d;

   logic [2:0]            rem_shift;
   logic                  rem_ge3;
   logic [1:0]            rem_next;
   logic [DATA_WIDTH-1:0] fuel;
   logic                  q_gt2;
   logic [WW-1:0]         total_wide;
   logic [WW-1:0]         part1_wide;
   logic                  total_cy;
   logic                  part1_cy;
   logic [ADDR_WIDTH-1:0] idx_inc;

   assign rem_shift  = {rem_q, m_q[DATA_WIDTH-1]};
   assign rem_ge3    = (rem_shift >= 3'd3);
   assign rem_next   = rem_ge3 ? 2'(rem_shift - 3'd3) : rem_shift[1:0];
   assign q_gt2      = (q_q > DATA_WIDTH'(2));
   assign fuel       = q_q - DATA_WIDTH'(2);
   assign total_wide = WW'(total_q) + WW'(fuel);
   assign part1_wide = WW'(part1_q) + WW'(fuel);
   assign total_cy   = |total_wide[WW-1:SUM_WIDTH];
   assign part1_cy   = |part1_wide[WW-1:SUM_WIDTH];
   assign idx_inc    = idx_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      idx_d    = idx_q;
      m_d      = m_q;
      q_d      = q_q;
      rem_d    = rem_q;
      bit_d    = bit_q;
      first_d  = first_q;
      part1_d  = part1_q;
      total_d  = total_q;
      ovf_d    = ovf_q;
      mem_rd   = 1'b0;
      mem_addr = '0;
      busy     = 1'b1;
      done     = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            busy = 1'b0;
            done = (state_q == S_DONE);
            if (start) begin
               count_d = count;
               idx_d   = '0;
               part1_d = '0;
               total_d = '0;
               ovf_d   = 1'b0;
               state_d = (count == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            mem_rd   = 1'b1;
            mem_addr = idx_q;
            state_d  = S_LOAD;
         end
         S_LOAD: begin
            m_d     = mem_data;
            first_d = 1'b1;
            q_d     = '0;
            rem_d   = '0;
            bit_d   = BIT_MSB;
            state_d = S_DIV;
         end
         S_DIV: begin
            m_d   = {m_q[DATA_WIDTH-2:0], 1'b0};
            q_d   = {q_q[DATA_WIDTH-2:0], rem_ge3};
            rem_d = rem_next;
            bit_d = bit_q - 1'b1;
            if (bit_q == '0) state_d = S_EVAL;
         end
         S_EVAL: begin
            if (q_gt2) begin
               total_d = total_wide[SUM_WIDTH-1:0];
               ovf_d   = ovf_q | total_cy | (first_q & part1_cy);
               if (first_q) part1_d = part1_wide[SUM_WIDTH-1:0];
               m_d     = fuel;
               first_d = 1'b0;
               q_d     = '0;
               rem_d   = '0;
               bit_d   = BIT_MSB;
               state_d = S_DIV;
            end else begin
               idx_d   = idx_inc;
               state_d = (idx_inc == count_q) ? S_DONE : S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         idx_q   <= '0;
         m_q     <= '0;
         q_q     <= '0;
         rem_q   <= '0;
         bit_q   <= '0;
         first_q <= 1'b0;
         part1_q <= '0;
         total_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         m_q     <= m_d;
         q_q     <= q_d;
         rem_q   <= rem_d;
         bit_q   <= bit_d;
         first_q <= first_d;
         part1_q <= part1_d;
         total_q <= total_d;
         ovf_q   <= ovf_d;
      end
   end

   assign part1_sum = part1_q;
   assign total_sum = total_q;
   assign ovf       = ovf_q;

endmodule
